// File: rtl/pci_burst_target.sv
// PCI memory target: ID decode, local word buffer, initial wait states, bursts, disconnect at buffer end.
// Optional address/data parity generation and checking when PCI_TGT_PARITY_EN is defined.
module pci_burst_target #(
    parameter int unsigned ID_W      = 2,
    parameter int unsigned DEV_ID    = 0,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned INIT_WAIT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef PCI_TGT_PARITY_EN
    input  logic                   par_i,
    output logic                   par_o,
    output logic                   par_oe,
    output logic                   perr_n_o,
    output logic                   perr_oe,
`endif
    input  logic [31:0]            ad_i,
    input  logic [3:0]             cbe_n_i,
    input  logic                   frame_n,
    input  logic                   irdy_n,
    output logic [31:0]            ad_o,
    output logic                   ad_oe,
    output logic                   devsel_n_o,
    output logic                   trdy_n_o,
    output logic                   stop_n_o,
    output logic                   ctl_oe,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] xfer_cnt
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WAIT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       CMD_MEM_RD = 4'b0110;
    localparam logic [3:0]       CMD_MEM_WR = 4'b0111;

    // The claim cycle is the first WAIT cycle; a zero load goes straight to DATA.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SKIP = 3'd1,
        S_WAIT = 3'd2,
        S_DATA = 3'd3,
        S_DISC = 3'd4,
        S_TURN = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                rd_q, rd_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [31:0]         mem_q [DEPTH];

    logic                hit_c;
    logic                xfer_c;
    logic [WAIT_W-1:0]   load_c;

    logic [31:0]         ad_o_d;
    logic                ad_oe_d, devsel_d, trdy_d, stop_d, ctl_oe_d, claimed_c;

    assign hit_c  = (ad_i[31 -: ID_W] == ID_W'(DEV_ID)) &&
                    ((cbe_n_i == CMD_MEM_RD) || (cbe_n_i == CMD_MEM_WR));
    assign load_c = (cbe_n_i == CMD_MEM_RD) ? WAIT_W'(INIT_WAIT + 1) : WAIT_W'(INIT_WAIT);
    assign xfer_c = (state_q == S_DATA) && !irdy_n && !trdy_n_o;

    // State, context, buffer and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            idx_q      <= '0;
            rd_q       <= 1'b0;
            xfer_cnt   <= '0;
            ad_o       <= '0;
            ad_oe      <= 1'b0;
            devsel_n_o <= 1'b1;
            trdy_n_o   <= 1'b1;
            stop_n_o   <= 1'b1;
            ctl_oe     <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            rd_q       <= rd_d;
            xfer_cnt   <= cnt_d;
            ad_o       <= ad_o_d;
            ad_oe      <= ad_oe_d;
            devsel_n_o <= devsel_d;
            trdy_n_o   <= trdy_d;
            stop_n_o   <= stop_d;
            ctl_oe     <= ctl_oe_d;
            busy       <= ctl_oe_d;
            if (xfer_c && !rd_q) begin
                for (int k = 0; k < 4; k++) begin
                    if (!cbe_n_i[k]) begin
                        mem_q[idx_q][8*k +: 8] <= ad_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Next-state and transaction context
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        cnt_d   = xfer_cnt;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    if (hit_c) begin
                        rd_d   = (cbe_n_i == CMD_MEM_RD);
                        idx_d  = ad_i[2 +: IDX_W];
                        cnt_d  = '0;
                        wait_d = load_c;
                        state_d = (load_c == '0) ? S_DATA : S_WAIT;
                    end else begin
                        state_d = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (frame_n && irdy_n) state_d = S_IDLE;
            end
            S_WAIT: begin
                wait_d = wait_q - WAIT_W'(1);
                if (wait_q <= WAIT_W'(1)) state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer_c) begin
                    cnt_d = xfer_cnt + CNT_W'(1);
                    if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
                    if (frame_n)                    state_d = S_TURN;
                    else if (idx_q == LAST_IDX)     state_d = S_DISC;
                end else if (frame_n) begin
                    state_d = S_TURN;
                end
            end
            S_DISC: begin
                if (frame_n) state_d = S_TURN;
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered bus outputs, decoded from the next state
    always_comb begin
        claimed_c = (state_d == S_WAIT) || (state_d == S_DATA) || (state_d == S_DISC);
        devsel_d  = !claimed_c;
        trdy_d    = (state_d != S_DATA);
        stop_d    = !(((state_d == S_DATA) && (idx_d == LAST_IDX)) || (state_d == S_DISC));
        ctl_oe_d  = claimed_c || (state_d == S_TURN);
        // Reads skip driving AD during the turnaround cycle right after the address phase.
        ad_oe_d   = rd_d && ((state_d == S_DATA) || (state_d == S_DISC) ||
                             ((state_d == S_WAIT) && (wait_d <= WAIT_W'(INIT_WAIT))));
        ad_o_d    = ad_oe_d ? mem_q[idx_d] : 32'h0;
    end

`ifdef PCI_TGT_PARITY_EN
    logic par_chk_q, par_exp_q, perr_pend_q;

    // Read parity trails data by one cycle; write parity error reported two edges after the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_o       <= 1'b0;
            par_oe      <= 1'b0;
            perr_n_o    <= 1'b1;
            perr_oe     <= 1'b0;
            par_chk_q   <= 1'b0;
            par_exp_q   <= 1'b0;
            perr_pend_q <= 1'b0;
        end else begin
            par_o       <= ^{ad_o, cbe_n_i};
            par_oe      <= ad_oe;
            par_chk_q   <= xfer_c && !rd_q;
            par_exp_q   <= ^{ad_i, cbe_n_i};
            perr_pend_q <= par_chk_q && (par_i != par_exp_q);
            perr_n_o    <= !perr_pend_q;
            perr_oe     <= (ctl_oe_d && !rd_d) || (ctl_oe && !rd_q) || perr_pend_q;
        end
    end
`endif

endmodule

// File: tb/tb_pci_burst_target.sv
// Directed bench for pci_burst_target: two targets (ID 0 no wait, ID 1 two waits) on one bus.
module tb_pci_burst_target;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ad_i;
    logic [3:0]  cbe_n_i;
    logic        frame_n, irdy_n;

    logic [31:0] a_ad_o, b_ad_o;
    logic        a_ad_oe, a_devsel, a_trdy, a_stop, a_ctl_oe, a_busy;
    logic        b_ad_oe, b_devsel, b_trdy, b_stop, b_ctl_oe, b_busy;
    logic [3:0]  a_xcnt, b_xcnt;
    logic [5:0]  a_ctl, b_ctl;

    localparam logic [5:0] CTL_IDLE = 6'b011100;

    assign a_ctl = {a_ad_oe, a_devsel, a_trdy, a_stop, a_ctl_oe, a_busy};
    assign b_ctl = {b_ad_oe, b_devsel, b_trdy, b_stop, b_ctl_oe, b_busy};

`ifdef PCI_TGT_PARITY_EN
    logic par_i;
    logic a_par_o, a_par_oe, a_perr_n, a_perr_oe;
    logic b_par_o, b_par_oe, b_perr_n, b_perr_oe;
`endif

    always #5 clk = ~clk;

    pci_burst_target #(.ID_W(2), .DEV_ID(0), .DEPTH(8), .INIT_WAIT(0)) u_dut_a (
        .clk(clk), .rst(rst),
`ifdef PCI_TGT_PARITY_EN
        .par_i(par_i), .par_o(a_par_o), .par_oe(a_par_oe),
        .perr_n_o(a_perr_n), .perr_oe(a_perr_oe),
`endif
        .ad_i(ad_i), .cbe_n_i(cbe_n_i), .frame_n(frame_n), .irdy_n(irdy_n),
        .ad_o(a_ad_o), .ad_oe(a_ad_oe), .devsel_n_o(a_devsel), .trdy_n_o(a_trdy),
        .stop_n_o(a_stop), .ctl_oe(a_ctl_oe), .busy(a_busy), .xfer_cnt(a_xcnt)
    );

    pci_burst_target #(.ID_W(2), .DEV_ID(1), .DEPTH(8), .INIT_WAIT(2)) u_dut_b (
        .clk(clk), .rst(rst),
`ifdef PCI_TGT_PARITY_EN
        .par_i(par_i), .par_o(b_par_o), .par_oe(b_par_oe),
        .perr_n_o(b_perr_n), .perr_oe(b_perr_oe),
`endif
        .ad_i(ad_i), .cbe_n_i(cbe_n_i), .frame_n(frame_n), .irdy_n(irdy_n),
        .ad_o(b_ad_o), .ad_oe(b_ad_oe), .devsel_n_o(b_devsel), .trdy_n_o(b_trdy),
        .stop_n_o(b_stop), .ctl_oe(b_ctl_oe), .busy(b_busy), .xfer_cnt(b_xcnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        ad_i    = 32'h0;
        cbe_n_i = 4'h0;
    endtask

    // Observations from the last master transaction
    int          o_first_trdy, o_first_devsel, o_n, o_tail;
    logic [31:0] o_rd [8];
    logic        o_stp [8];
    bit          o_disc_ok, o_other;
    logic [31:0] wdat [8];

    // Master: address phase, back-to-back data phases, honours target disconnect
    task automatic xact(input bit d, input logic [31:0] addr, input logic [3:0] cmd,
                        input int n, input logic [3:0] be);
        int          cyc;
        int          k;
        int          t;
        bit          done;
        bit          wr;
        logic        p_trdy, p_stop;
        logic [31:0] p_ad;
        wr = cmd[0];
        cyc = 0; k = 0; done = 0;
        o_first_trdy = -1; o_first_devsel = -1; o_tail = -1;
        o_disc_ok = 1; o_other = 0;
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = addr; cbe_n_i = cmd;
        tick();
        cyc = 1;
        frame_n = (n == 1); irdy_n = 1'b0; ad_i = wr ? wdat[0] : 32'h0; cbe_n_i = be;
        while (!done) begin
            p_trdy = d ? b_trdy : a_trdy;
            p_stop = d ? b_stop : a_stop;
            p_ad   = d ? b_ad_o : a_ad_o;
            if (!p_trdy && o_first_trdy < 0) o_first_trdy = cyc;
            if (!(d ? b_devsel : a_devsel) && o_first_devsel < 0) o_first_devsel = cyc;
            if (d ? a_ctl_oe : b_ctl_oe) o_other = 1;
            tick();
            cyc++;
            if (!p_trdy) begin
                o_rd[k] = p_ad;
                o_stp[k] = !p_stop;
                k++;
                if (frame_n) begin
                    done = 1;
                end else if (!p_stop) begin
                    for (int i = 0; i < 2; i++) begin
                        if (!(d ? b_trdy : a_trdy) || (d ? b_stop : a_stop)) o_disc_ok = 0;
                        tick();
                    end
                    bus_idle();
                    tick();
                    done = 1;
                end else begin
                    frame_n = (k == n - 1);
                    ad_i = wr ? wdat[k] : 32'h0;
                end
            end
            if (!done && cyc > 40) begin
                chk("xact_timeout", 32'(cyc), 32'd40);
                done = 1;
            end
        end
        o_n = k;
        bus_idle();
        t = 0;
        while ((d ? b_ctl_oe : a_ctl_oe) && t < 8) begin
            tick();
            t++;
        end
        o_tail = t;
    endtask

    // Address phase that neither target may claim
    task automatic miss(input string tag, input logic [31:0] addr, input logic [3:0] cmd);
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = addr; cbe_n_i = cmd;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "_ctl_oe"}, {30'h0, a_ctl_oe, b_ctl_oe}, 32'h0);
            chk({tag, "_devsel"}, {30'h0, a_devsel, b_devsel}, 32'h3);
            if (i == 0) begin
                frame_n = 1'b1; irdy_n = 1'b0; ad_i = 32'hFFFF_FFFF; cbe_n_i = 4'h0;
            end else begin
                bus_idle();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_idle();
`ifdef PCI_TGT_PARITY_EN
        par_i = 1'b0;
`endif
        tick();
        tick();
        chk("rst_a_ctl", 32'(a_ctl), 32'(CTL_IDLE));
        chk("rst_b_ctl", 32'(b_ctl), 32'(CTL_IDLE));
        chk("rst_a_xcnt", 32'(a_xcnt), 32'h0);
        chk("rst_b_xcnt", 32'(b_xcnt), 32'h0);
        chk("rst_a_ad_o", a_ad_o, 32'h0);
        rst = 1'b0;
        tick();

        // Single write, no wait states: claim and TRDY# both at T1
        wdat[0] = 32'hDEAD_BEEF;
        xact(0, 32'h0000_0008, 4'b0111, 1, 4'b0000);
        chk("w1_devsel_cyc", 32'(o_first_devsel), 32'd1);
        chk("w1_trdy_cyc", 32'(o_first_trdy), 32'd1);
        chk("w1_n", 32'(o_n), 32'd1);
        chk("w1_xcnt", 32'(a_xcnt), 32'd1);
        chk("w1_tail", 32'(o_tail), 32'd1);
        chk("w1_other", 32'(o_other), 32'd0);

        // Read back word 2: turnaround pushes TRDY# to T2
        xact(0, 32'h0000_0008, 4'b0110, 1, 4'b0000);
        chk("r1_trdy_cyc", 32'(o_first_trdy), 32'd2);
        chk("r1_data", o_rd[0], 32'hDEAD_BEEF);
        chk("r1_xcnt", 32'(a_xcnt), 32'd1);

        // Target B preload: write burst of 3 from index 1 with 2 wait states
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33;
        xact(1, 32'h4000_0004, 4'b0111, 3, 4'b0000);
        chk("bw_trdy_cyc", 32'(o_first_trdy), 32'd3);
        chk("bw_n", 32'(o_n), 32'd3);
        chk("bw_xcnt", 32'(b_xcnt), 32'd3);
        chk("bw_other", 32'(o_other), 32'd0);

        // Target B read burst of 3: first TRDY# at T4
        xact(1, 32'h4000_0004, 4'b0110, 3, 4'b0000);
        chk("br_trdy_cyc", 32'(o_first_trdy), 32'd4);
        chk("br_d0", o_rd[0], 32'h11);
        chk("br_d1", o_rd[1], 32'h22);
        chk("br_d2", o_rd[2], 32'h33);
        chk("br_xcnt", 32'(b_xcnt), 32'd3);

        // Write burst at DEPTH-2 requesting 4 phases: disconnect with data at index 7
        wdat[0] = 32'h6666_6666; wdat[1] = 32'h7777_7777;
        wdat[2] = 32'h8888_8888; wdat[3] = 32'h9999_9999;
        xact(0, 32'h0000_0018, 4'b0111, 4, 4'b0000);
        chk("dw_n", 32'(o_n), 32'd2);
        chk("dw_stop0", 32'(o_stp[0]), 32'd0);
        chk("dw_stop1", 32'(o_stp[1]), 32'd1);
        chk("dw_hold", 32'(o_disc_ok), 32'd1);
        chk("dw_xcnt", 32'(a_xcnt), 32'd2);
        chk("dw_tail", 32'(o_tail), 32'd1);

        // Last phase at index 7 together with STOP#
        xact(0, 32'h0000_0018, 4'b0110, 2, 4'b0000);
        chk("dr_d0", o_rd[0], 32'h6666_6666);
        chk("dr_d1", o_rd[1], 32'h7777_7777);
        chk("dr_stop1", 32'(o_stp[1]), 32'd1);
        chk("dr_n", 32'(o_n), 32'd2);
        chk("dr_tail", 32'(o_tail), 32'd1);

        // No wrap-around: word 0 untouched
        xact(0, 32'h0000_0000, 4'b0110, 1, 4'b0000);
        chk("nowrap_d0", o_rd[0], 32'h0);

        // Byte enables 1010 write lanes 0 and 2 only
        wdat[0] = 32'hFFFF_FFFF;
        xact(0, 32'h0000_0010, 4'b0111, 1, 4'b1010);
        xact(0, 32'h0000_0010, 4'b0110, 1, 4'b0000);
        chk("be_word", o_rd[0], 32'h00FF_00FF);

        miss("miss_id2", 32'h8000_0000, 4'b0111);
        miss("miss_iocmd", 32'h0000_0008, 4'b0011);

        // Stall inside a target B read burst, then reset during DATA
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = 32'h4000_0004; cbe_n_i = 4'b0110;
        tick();
        irdy_n = 1'b0; ad_i = 32'h0; cbe_n_i = 4'h0;
        tick();
        tick();
        tick();
        chk("st_trdy", 32'(b_trdy), 32'd0);
        chk("st_d0", b_ad_o, 32'h11);
        tick();
        chk("st_d1", b_ad_o, 32'h22);
        chk("st_xcnt1", 32'(b_xcnt), 32'd1);
        irdy_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ad", b_ad_o, 32'h22);
            chk("stall_xcnt", 32'(b_xcnt), 32'd1);
            chk("stall_trdy", 32'(b_trdy), 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("mrst_b_ctl", 32'(b_ctl), 32'(CTL_IDLE));
        chk("mrst_b_ad_o", b_ad_o, 32'h0);
        chk("mrst_b_xcnt", 32'(b_xcnt), 32'h0);
        rst = 1'b0;
        bus_idle();
        tick();

        // Buffer cleared by reset
        xact(1, 32'h4000_0004, 4'b0110, 1, 4'b0000);
        chk("post_rst_trdy_cyc", 32'(o_first_trdy), 32'd4);
        chk("post_rst_data", o_rd[0], 32'h0);

`ifdef PCI_TGT_PARITY_EN
        // Write of 0x1 with BE 0000 needs PAR=1; drive 0 to force PERR#
        frame_n = 1'b0; irdy_n = 1'b1; ad_i = 32'h0000_0014; cbe_n_i = 4'b0111;
        tick();
        frame_n = 1'b1; irdy_n = 1'b0; ad_i = 32'h1; cbe_n_i = 4'h0;
        tick();
        bus_idle();
        par_i = 1'b0;
        chk("perr_e1", 32'(a_perr_n), 32'd1);
        tick();
        chk("perr_e2", 32'(a_perr_n), 32'd1);
        tick();
        chk("perr_e3", 32'(a_perr_n), 32'd0);
        chk("perr_oe_e3", 32'(a_perr_oe), 32'd1);
        tick();
        chk("perr_e4", 32'(a_perr_n), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pci_burst_target.md
Name: pci_burst_target

Overview:
- Second-generation PCI target for the device controller. Replaces the fixed single-phase target path with parametrised address decode, a local word buffer, programmable initial wait states, multi-phase bursts, and target disconnect at the buffer end.
- Sits between the shared PCI bus pads and the device.
- All tri-states are split into _i/_o/_oe triplets. The top level builds the inouts from these.

Parameters:
- ID_W, 2: width of the device ID field decoded from AD[31:32-ID_W].
- DEV_ID, 0: ID value this target claims.
- DEPTH, 8: number of 32-bit buffer words. Must be a power of two, 2..64.
- INIT_WAIT, 0: extra wait states, 0..7, inserted before the first TRDY# of a transaction.

Ports:
- clk  in  1  bus clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- ad_i  in  32  sampled AD bus
- cbe_n_i  in  4  sampled C/BE#: command in address phase, byte enables in data phases
- frame_n  in  1  FRAME#, active low
- irdy_n  in  1  IRDY#, active low
- ad_o  out  32  read data driven onto AD
- ad_oe  out  1  AD output enable
- devsel_n_o  out  1  DEVSEL# drive value
- trdy_n_o  out  1  TRDY# drive value
- stop_n_o  out  1  STOP# drive value
- ctl_oe  out  1  shared enable for DEVSEL#/TRDY#/STOP#
- busy  out  1  high from claim until back in IDLE
- xfer_cnt  out  $clog2(DEPTH)+1  data phases completed in the current or last transaction

Behaviour:
- Reset: state IDLE, ad_o=0, ad_oe=0, devsel_n_o=1, trdy_n_o=1, stop_n_o=1, ctl_oe=0, busy=0, xfer_cnt=0, all buffer words=0.
  - Reset asserted mid-transaction aborts the transaction immediately. Outputs return to reset values on the next edge with no turnaround.
- Address phase (cycle T0): the cycle in IDLE where frame_n=0 is first sampled.
  - Hit when ad_i[31:32-ID_W]==DEV_ID and cbe_n_i is 4'b0110 (memory read) or 4'b0111 (memory write).
  - On a hit, latch the command and the start index ad_i[2 +: $clog2(DEPTH)], clear xfer_cnt, and go to CLAIM.
  - A miss or any other command stays in IDLE. The target ignores the bus until frame_n=1 and irdy_n=1 are both sampled.
- CLAIM (T1): ctl_oe=1, devsel_n_o=0, busy=1. Load the wait counter.
  - Write: wait counter = INIT_WAIT.
  - Read: wait counter = INIT_WAIT+1, giving a mandatory AD turnaround cycle.
  - From T2 on a read, ad_oe=1 and ad_o=buf[index].
- WAIT: decrement the counter each cycle. At zero, go to DATA with trdy_n_o=0.
- DATA: a transfer occurs on an edge where irdy_n=0 and trdy_n_o=0.
  - Write: update buf[index] only on lanes where cbe_n_i[k]=0.
  - On each transfer, index increments by 1 and xfer_cnt increments by 1.
  - Read: ad_o updates to the new buf[index] in the same cycle trdy_n_o stays low, so there are no wait states within a burst.
  - irdy_n=1 with trdy_n_o=0: hold all outputs and stall with no transfer.
- Disconnect: while index==DEPTH-1 in DATA, drive stop_n_o=0 together with trdy_n_o=0 (disconnect with data). No wrap-around occurs.
  - After that transfer, drive trdy_n_o=1 and keep stop_n_o=0 until frame_n=1 is sampled.
- Completion:
  - A transfer with frame_n=1 is the last phase; go to TURN.
  - frame_n=1 with irdy_n=1 in DATA (master abort of the burst) also goes to TURN.
- TURN: one cycle with devsel_n_o=trdy_n_o=stop_n_o=1, ctl_oe=1, ad_oe=0. Then go to IDLE with ctl_oe=0 and busy=0.
  - Back-to-back address phases are only recognised from IDLE.
- Simultaneous events:
  - Last-phase transfer at index DEPTH-1: STOP# is asserted, the transfer completes, and the next state is TURN.

Optional Feature:
- Macro PCI_TGT_PARITY_EN.
- Defined: adds ports par_i (in, 1), par_o (out, 1), par_oe (out, 1), perr_n_o (out, 1), perr_oe (out, 1).
  - Reads: par_o = even parity over ad_o and the C/BE# value sampled that cycle, driven one cycle after the data with par_oe asserted one cycle after ad_oe.
  - Writes: parity is checked one cycle after each transfer. On mismatch, perr_n_o=0 for one cycle two edges after the transfer, with perr_oe high while the transaction is claimed plus one cycle.
  - Reset: par_o=0, par_oe=0, perr_n_o=1, perr_oe=0.
- Undefined: none of these ports exist and no parity logic is present.

Test Plan:
- Single write, DEV_ID=0, INIT_WAIT=0: addr 0x0000_0008, cmd 0111, data 0xDEADBEEF, BE 0000, frame_n high in the phase -> devsel_n_o low at T1, trdy_n_o low at T1, buf[2]=0xDEADBEEF, xfer_cnt=1, ctl_oe low 2 cycles after the transfer.
- Read burst of 3 from index 1, INIT_WAIT=2, buf preloaded 0x11,0x22,0x33 -> first trdy_n_o low at T4, ad_o sequence 0x11,0x22,0x33 on consecutive transfers, xfer_cnt=3.
- Burst at index DEPTH-2 with the initiator requesting 4 phases -> stop_n_o=0 with the transfer at index 7, exactly 2 transfers, trdy_n_o high afterwards until frame_n=1.
- Write with BE=1010 over word 0xFFFFFFFF -> buf word becomes 0x00FF00FF; address with ID=2 -> no devsel_n_o assertion, ctl_oe stays 0.
- irdy_n held high 3 cycles mid-burst, then rst asserted during DATA -> no index advance during the stall; after rst all outputs at reset values on the next edge and busy=0.
- With PCI_TGT_PARITY_EN, a write with a wrong par_i -> perr_n_o=0 for exactly one cycle, two edges after the transfer.
